// File: rtl/msrv32_imm_gen_pipe.sv
// rtl/msrv32_imm_gen_pipe.sv - msrv32 decode immediate generator with pc-relative target, valid/ready output stage
// Optional feature macro: MSRV32_IMG_ILLEGAL_CHK_EN (adds illegal_out, flags imm_type_in=111)
module msrv32_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [24:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [XLEN-1:0]  imm_out,
  output logic [XLEN-1:0]  target_out,
  output logic [TAG_W-1:0] tag_out
`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
  ,
  output logic             illegal_out
`endif
);

  // instr_in[k] carries instruction bit k+7, so instruction bit n is instr_in[n-7].
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] target_c;

`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
  localparam int EW = 2*XLEN + TAG_W + 1;
  logic illegal_c;
`else
  localparam int EW = 2*XLEN + TAG_W;
`endif

  logic          main_valid;
  logic [EW-1:0] main_q;
  logic [EW-1:0] in_entry;

  // Expand the immediate to 32 bits, then sign-extend to XLEN from bit 31
  always_comb begin
    imm32 = {{20{instr_in[24]}}, instr_in[24:13]};
    case (imm_type_in)
      3'b010:  imm32 = {{20{instr_in[24]}}, instr_in[24:18], instr_in[4:0]};
      3'b011:  imm32 = {{19{instr_in[24]}}, instr_in[24], instr_in[0],
                        instr_in[23:18], instr_in[4:1], 1'b0};
      3'b100:  imm32 = {instr_in[24:5], 12'h000};
      3'b101:  imm32 = {{11{instr_in[24]}}, instr_in[24], instr_in[12:5],
                        instr_in[13], instr_in[23:14], 1'b0};
      3'b110:  imm32 = {27'h0, instr_in[12:8]};
      default: imm32 = {{20{instr_in[24]}}, instr_in[24:13]};
    endcase
    imm_c        = {XLEN{imm32[31]}};
    imm_c[31:0]  = imm32;
`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
    illegal_c = (imm_type_in == 3'b111);
    if (illegal_c) imm_c = '0;
`endif
  end

  assign target_c = pc_in + imm_c;

`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
  assign in_entry    = {illegal_c, imm_c, target_c, tag_in};
  assign illegal_out = main_q[EW-1];
`else
  assign in_entry    = {imm_c, target_c, tag_in};
`endif

  assign valid_out = main_valid;
  assign {imm_out, target_out, tag_out} = main_q[2*XLEN+TAG_W-1:0];

  generate
    if (SKID != 0) begin : g_skid
      logic          skid_valid;
      logic [EW-1:0] skid_q;
      logic          accept;
      logic          drain;

      assign ready_out = !skid_valid && !rst_in;
      assign accept    = valid_in && ready_out && !flush_in;
      assign drain     = main_valid && ready_in;

      // Main/skid pair: skid only fills while main is stalled and refills main when it drains
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_q     <= '0;
          skid_q     <= '0;
        end else if (flush_in) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
          if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
          end else begin
            main_valid <= accept;
            if (accept) main_q <= in_entry;
          end
        end else if (accept) begin
          skid_q     <= in_entry;
          skid_valid <= 1'b1;
        end
      end
    end else begin : g_single
      logic accept;
      logic drain;

      assign ready_out = (!main_valid || ready_in) && !rst_in;
      assign accept    = valid_in && ready_out && !flush_in;
      assign drain     = main_valid && ready_in;

      // Single output register; a new entry may replace the one draining this cycle
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          main_valid <= 1'b0;
          main_q     <= '0;
        end else if (flush_in) begin
          main_valid <= 1'b0;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_q     <= in_entry;
        end else if (drain) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_msrv32_imm_gen_pipe.sv
// tb/tb_msrv32_imm_gen_pipe.sv - self-checking bench for msrv32_imm_gen_pipe (XLEN=32 SKID=1 and XLEN=64 SKID=0)
module tb_msrv32_imm_gen_pipe;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  typ;
    logic [63:0] pc;
    logic [4:0]  tag;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_valid_in, a_ready_out, a_valid_out, a_ready_in, a_ill;
  logic [24:0] a_instr;
  logic [2:0]  a_typ;
  logic [31:0] a_pc, a_imm_out, a_tgt_out;
  logic [4:0]  a_tag, a_tag_out;

  logic        b_flush, b_valid_in, b_ready_out, b_valid_out, b_ready_in, b_ill;
  logic [24:0] b_instr;
  logic [2:0]  b_typ;
  logic [63:0] b_pc, b_imm_out, b_tgt_out;
  logic [4:0]  b_tag, b_tag_out;

  vec_t a_pend, b_pend, ea, eb;
  vec_t qa[$];
  vec_t qb[$];
  vec_t va[9];
  vec_t vb[5];

  msrv32_imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) dut_a (
    .clk_in(clk), .rst_in(rst), .flush_in(a_flush), .valid_in(a_valid_in),
    .ready_out(a_ready_out), .instr_in(a_instr), .imm_type_in(a_typ), .pc_in(a_pc),
    .tag_in(a_tag), .valid_out(a_valid_out), .ready_in(a_ready_in),
    .imm_out(a_imm_out), .target_out(a_tgt_out), .tag_out(a_tag_out)
`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
    , .illegal_out(a_ill)
`endif
  );

  msrv32_imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(0)) dut_b (
    .clk_in(clk), .rst_in(rst), .flush_in(b_flush), .valid_in(b_valid_in),
    .ready_out(b_ready_out), .instr_in(b_instr), .imm_type_in(b_typ), .pc_in(b_pc),
    .tag_in(b_tag), .valid_out(b_valid_out), .ready_in(b_ready_in),
    .imm_out(b_imm_out), .target_out(b_tgt_out), .tag_out(b_tag_out)
`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
    , .illegal_out(b_ill)
`endif
  );

`ifndef MSRV32_IMG_ILLEGAL_CHK_EN
  assign a_ill = 1'b0;
  assign b_ill = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int t);
    vec_t v;
    v.ins = 32'h00100093;
    v.typ = 3'd1;
    v.pc  = 64'(t * 16);
    v.tag = 5'(t);
    v.imm = 64'd1;
    v.tgt = 64'(t * 16 + 1);
    v.ill = 1'b0;
    return v;
  endfunction

  task automatic drive_a(input vec_t v);
    a_valid_in = 1'b1;
    a_instr    = v.ins[31:7];
    a_typ      = v.typ;
    a_pc       = v.pc[31:0];
    a_tag      = v.tag;
    a_pend     = v;
  endtask

  task automatic drive_b(input vec_t v);
    b_valid_in = 1'b1;
    b_instr    = v.ins[31:7];
    b_typ      = v.typ;
    b_pc       = v.pc;
    b_tag      = v.tag;
    b_pend     = v;
  endtask

  task automatic send_a(input vec_t v);
    bit done = 1'b0;
    int n = 0;
    drive_a(v);
    while (!done && n < 50) begin
      @(negedge clk);
      done = a_ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    a_valid_in = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_a_timeout: tag %0d not accepted within %0d cycles", v.tag, n);
    end
  endtask

  task automatic send_b(input vec_t v);
    bit done = 1'b0;
    int n = 0;
    drive_b(v);
    while (!done && n < 50) begin
      @(negedge clk);
      done = b_ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    b_valid_in = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_b_timeout: tag %0d not accepted within %0d cycles", v.tag, n);
    end
  endtask

  // Scoreboard: compare each consumed output with the oldest accepted entry, then record new accepts
  always @(negedge clk) begin
    if (a_valid_out && a_ready_in) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_spurious: got output tag %0d expected no output", a_tag_out);
      end else begin
        ea = qa.pop_front();
        chk("a_imm", 64'(a_imm_out), ea.imm & 64'hFFFF_FFFF);
        chk("a_target", 64'(a_tgt_out), ea.tgt & 64'hFFFF_FFFF);
        chk("a_tag", 64'(a_tag_out), 64'(ea.tag));
`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
        chk("a_illegal", 64'(a_ill), 64'(ea.ill));
`endif
      end
    end
    if (rst || a_flush) qa.delete();
    else if (a_valid_in && a_ready_out) qa.push_back(a_pend);

    if (b_valid_out && b_ready_in) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_spurious: got output tag %0d expected no output", b_tag_out);
      end else begin
        eb = qb.pop_front();
        chk("b_imm", b_imm_out, eb.imm);
        chk("b_target", b_tgt_out, eb.tgt);
        chk("b_tag", 64'(b_tag_out), 64'(eb.tag));
`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
        chk("b_illegal", 64'(b_ill), 64'(eb.ill));
`endif
      end
    end
    if (rst || b_flush) qb.delete();
    else if (b_valid_in && b_ready_out) qb.push_back(b_pend);
  end

  initial begin
    va[0] = '{32'hFFF00093, 3'd1, 64'h0,    5'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0};
    va[1] = '{32'hFE000EE3, 3'd3, 64'h100,  5'd2, 64'hFFFFFFFC, 64'h000000FC, 1'b0};
    va[2] = '{32'h0080006F, 3'd5, 64'h200,  5'd3, 64'h8,        64'h208,      1'b0};
    va[3] = '{32'hFFFFF073, 3'd6, 64'h300,  5'd4, 64'h1F,       64'h31F,      1'b0};
    va[4] = '{32'h00112A23, 3'd2, 64'h10,   5'd5, 64'h14,       64'h24,       1'b0};
    va[5] = '{32'h800000B7, 3'd4, 64'h1000, 5'd6, 64'h80000000, 64'h80001000, 1'b0};
`ifdef MSRV32_IMG_ILLEGAL_CHK_EN
    va[6] = '{32'h7FF00013, 3'd7, 64'h40,   5'd7, 64'h0,        64'h40,       1'b1};
`else
    va[6] = '{32'h7FF00013, 3'd7, 64'h40,   5'd7, 64'h7FF,      64'h83F,      1'b0};
`endif
    va[7] = '{32'h00B50533, 3'd0, 64'h0,    5'd8, 64'hB,        64'hB,        1'b0};
    va[8] = '{32'hFFDFF06F, 3'd5, 64'h400,  5'd9, 64'hFFFFFFFC, 64'h3FC,      1'b0};

    vb[0] = '{32'h800000B7, 3'd4, 64'h0,                   5'd1, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
    vb[1] = '{32'h800000B7, 3'd3, 64'hFFFFFFFFFFFFFFF0,    5'd2, 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFFFFFFF7F0, 1'b0};
    vb[2] = '{32'hFFF00093, 3'd1, 64'h0,                   5'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vb[3] = '{32'h0080006F, 3'd5, 64'hFFFFFFFFFFFFFFFC,    5'd4, 64'h8,                64'h4,                1'b0};
    vb[4] = '{32'hFFFFF073, 3'd6, 64'h0,                   5'd5, 64'h1F,               64'h1F,               1'b0};

    rst = 1'b1;
    a_flush = 1'b0; a_valid_in = 1'b0; a_ready_in = 1'b1;
    a_instr = '0; a_typ = '0; a_pc = '0; a_tag = '0;
    b_flush = 1'b0; b_valid_in = 1'b0; b_ready_in = 1'b1;
    b_instr = '0; b_typ = '0; b_pc = '0; b_tag = '0;
    a_pend = mk(0);
    b_pend = mk(0);

    // Reset state
    @(negedge clk);
    chk("a_ready_in_reset", 64'(a_ready_out), 64'd0);
    chk("b_ready_in_reset", 64'(b_ready_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("a_valid_after_reset", 64'(a_valid_out), 64'd0);
    chk("a_imm_after_reset", 64'(a_imm_out), 64'd0);
    chk("a_target_after_reset", 64'(a_tgt_out), 64'd0);
    chk("a_tag_after_reset", 64'(a_tag_out), 64'd0);
    chk("a_ready_after_reset", 64'(a_ready_out), 64'd1);
    chk("b_valid_after_reset", 64'(b_valid_out), 64'd0);
    chk("b_ready_after_reset", 64'(b_ready_out), 64'd1);
    @(posedge clk); #1;

    // Format table, streamed back to back
    for (int i = 0; i < 9; i++) send_a(va[i]);
    for (int i = 0; i < 5; i++) send_b(vb[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("a_table_drained", 64'(qa.size()), 64'd0);
    chk("b_table_drained", 64'(qb.size()), 64'd0);

    // SKID=0: combinational ready, accept and drain in the same cycle
    b_ready_in = 1'b0;
    send_b(vb[0]);
    @(negedge clk);
    chk("b_ready_stalled", 64'(b_ready_out), 64'd0);
    chk("b_valid_stalled", 64'(b_valid_out), 64'd1);
    @(posedge clk); #1;
    b_ready_in = 1'b1;
    @(negedge clk);
    chk("b_ready_comb", 64'(b_ready_out), 64'd1);
    @(posedge clk); #1;
    b_ready_in = 1'b0;
    send_b(vb[3]);
    b_ready_in = 1'b1;
    send_b(vb[2]);
    repeat (2) @(posedge clk);
    #1;
    chk("b_bp_drained", 64'(qb.size()), 64'd0);

    // SKID=1 backpressure: two accepts, then ready drops; release gives tags 1..4 one per cycle
    send_a(mk(1));
    a_ready_in = 1'b0;
    send_a(mk(2));
    drive_a(mk(3));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("a_ready_full", 64'(a_ready_out), 64'd0);
      chk("a_hold_valid", 64'(a_valid_out), 64'd1);
      chk("a_hold_tag", 64'(a_tag_out), 64'd1);
      chk("a_hold_target", 64'(a_tgt_out), 64'h11);
      @(posedge clk); #1;
    end
    a_ready_in = 1'b1;
    fork
      begin
        send_a(mk(3));
        send_a(mk(4));
      end
      begin
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk);
          chk("a_stream_valid", 64'(a_valid_out), 64'd1);
          chk("a_stream_tag", 64'(a_tag_out), 64'(k));
        end
      end
    join
    @(posedge clk); #1;
    chk("a_stream_drained", 64'(qa.size()), 64'd0);

    // Flush with main and skid both full, input presented in the flush cycle
    a_ready_in = 1'b0;
    send_a(mk(5));
    send_a(mk(6));
    @(negedge clk);
    chk("a_full_before_flush", 64'({a_valid_out, a_ready_out}), 64'b10);
    @(posedge clk); #1;
    drive_a(mk(7));
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    a_valid_in = 1'b0;
    @(negedge clk);
    chk("a_flush_valid", 64'(a_valid_out), 64'd0);
    chk("a_flush_ready", 64'(a_ready_out), 64'd1);
    a_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("a_flush_no_emit", 64'(a_valid_out), 64'd0);
    end
    @(posedge clk); #1;

    // Flush while ready: the flush-cycle input is dropped
    drive_a(mk(9));
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    a_valid_in = 1'b0;
    @(negedge clk);
    chk("a_flush_drop", 64'(a_valid_out), 64'd0);
    @(posedge clk); #1;

    // Reset mid-stall
    a_ready_in = 1'b0;
    send_a(va[1]);
    @(negedge clk);
    chk("a_stall_valid", 64'(a_valid_out), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("a_ready_during_reset", 64'(a_ready_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("a_rst_valid", 64'(a_valid_out), 64'd0);
    chk("a_rst_imm", 64'(a_imm_out), 64'd0);
    chk("a_rst_target", 64'(a_tgt_out), 64'd0);
    chk("a_rst_tag", 64'(a_tag_out), 64'd0);
    chk("a_rst_illegal", 64'(a_ill), 64'd0);
    chk("a_rst_ready", 64'(a_ready_out), 64'd1);
    a_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("a_final_queue", 64'(qa.size()), 64'd0);
    chk("b_final_queue", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msrv32_imm_gen_pipe.md
Name: msrv32_imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the msrv32 decode stage.
- Expands the instruction immediate to XLEN bits and computes the PC-relative target (pc + imm) in the same stage.
- Results are registered behind a valid/ready handshake with an optional skid buffer, so decode can backpressure without losing throughput.
- Sits between instruction fetch/decode and the branch unit/ALU operand mux.

Parameters:
- XLEN, 32, datapath width (32 or 64). Immediate and target are sign-extended to XLEN.
- TAG_W, 5, width of the sideband tag carried alongside each entry (e.g. rd index).
- SKID, 1. 1 = two-entry skid buffer with registered ready_out and full throughput. 0 = single register with combinational ready_out.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- flush_in  input  1  discard all held entries
- valid_in  input  1  upstream entry valid
- ready_out  output  1  block can accept an entry
- instr_in  input  25  instruction bits [31:7]
- imm_type_in  input  3  immediate format from decoder
- pc_in  input  XLEN  PC of the instruction
- tag_in  input  TAG_W  sideband tag
- valid_out  output  1  output entry valid
- ready_in  input  1  downstream accepts the entry
- imm_out  output  XLEN  expanded immediate
- target_out  output  XLEN  pc + imm_out, modulo 2^XLEN
- tag_out  output  TAG_W  tag of the output entry

Behaviour:
- Formats, with s = instr[31] sign-extended to XLEN:
  - 000 R and 001 I: instr[31:20], sign-extended.
  - 010 S: {instr[31:25], instr[11:7]}, sign-extended.
  - 011 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - 100 U: {instr[31:12], 12'h000}, sign-extended from bit 31 (RV64 LUI semantics).
  - 101 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - 110 CSR: zero-extended instr[19:15].
  - 111: I format.
- Transfer rules: input is accepted when valid_in && ready_out; output is consumed when valid_out && ready_in.
- Latency: one cycle from an accepted input to valid_out.
- Output stability: imm_out, target_out and tag_out hold steady while valid_out && !ready_in.
- SKID=1, main and skid registers:
  - Accept while main is empty or draining: the entry goes to main.
  - Accept while main is stalled: the entry goes to skid, and ready_out drops on the next cycle.
  - When main drains: skid moves to main, and ready_out rises on the next cycle.
  - ready_out = !skid_valid (registered).
  - Back-to-back streaming with ready_in=1 sustains 1 entry/cycle.
- SKID=0: ready_out = !valid_out || ready_in. Accept and drain may happen in the same cycle.
- flush_in:
  - Clears main and skid valid on the next edge, so valid_out=0 in the following cycle.
  - Any input presented in the flush cycle is dropped.
  - Flush takes priority over accept and drain.
- Reset:
  - At the clock edge with rst_in=1: valid_out=0, imm_out=0, target_out=0, tag_out=0, skid cleared.
  - ready_out=0 while rst_in=1, and 1 in the first cycle after reset.
  - Reset mid-stall discards all entries.
- Data registers update only on accept/shift, which keeps toggling low when idle.

Optional Feature:
- Macro: MSRV32_IMG_ILLEGAL_CHK_EN.
- Defined:
  - Adds port illegal_out (output, 1 bit), registered with the entry; reset value 0.
  - imm_type_in=111 sets illegal_out=1, imm_out=0, target_out=pc_in.
  - illegal_out follows the same handshake as the other outputs.
- Undefined: no illegal_out port; 111 decodes as I format.

Test Plan:
- Format check, XLEN=32:
  - addi instr 0xFFF00093 ([31:7]), type 001, pc 0x0 -> imm_out 0xFFFFFFFF.
  - beq 0xFE000EE3, type 011, pc 0x100 -> imm_out 0xFFFFFFFC, target_out 0x000000FC.
  - jal 0x0080006F, type 101, pc 0x200 -> imm_out 0x8, target_out 0x208.
  - csrrwi with instr[19:15]=0x1F, type 110 -> imm_out 0x0000001F.
- XLEN=64: lui 0x800000B7, type 100 -> imm_out 0xFFFFFFFF80000000. Same entry with pc 0xFFFFFFFFFFFFFFF0 and type 011 wraps target modulo 2^64.
- SKID=1 backpressure: stream 4 entries (tags 1..4) with valid_in=1 and hold ready_in=0 from cycle 2 -> ready_out low after two accepts. Release ready_in -> tags appear in order 1..4, none lost or duplicated, one per cycle.
- Flush: with main and skid both full, assert flush_in together with valid_in -> valid_out=0 next cycle, the flush-cycle input is not emitted, ready_out=1.
- Reset mid-stall: valid_out=1, ready_in=0, then rst_in high for 1 cycle -> all outputs 0, ready_out=0 during reset and 1 the cycle after.
- With MSRV32_IMG_ILLEGAL_CHK_EN defined, type 111, pc 0x40 -> illegal_out=1, imm_out=0, target_out=0x40.
